// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, AxPROT bit positions and the
// master FSM state encoding.
package axi4lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int PRIV   = 0;
    localparam int NONSEC = 1;
    localparam int INSTR  = 2;

    // Prefixed so the members never collide with AXI port names such as RDATA.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP
    } master_state_t;

endpackage

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into AW/W/B or AR/R
// traffic and returns a single registered response.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STRB  = WIDTH / 8
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    input  logic [STRB-1:0]  cmd_wstrb,
    input  logic [2:0]       cmd_prot,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [1:0]       rsp_resp,
    output logic             AWVALID,
    input  logic             AWREADY,
    output logic [WIDTH-1:0] AWADDR,
    output logic [2:0]       AWPROT,
    output logic             WVALID,
    input  logic             WREADY,
    output logic [WIDTH-1:0] WDATA,
    output logic [STRB-1:0]  WSTRB,
    input  logic             BVALID,
    output logic             BREADY,
    input  logic [1:0]       BRESP,
    output logic             ARVALID,
    input  logic             ARREADY,
    output logic [WIDTH-1:0] ARADDR,
    output logic [2:0]       ARPROT,
    input  logic             RVALID,
    output logic             RREADY,
    input  logic [WIDTH-1:0] RDATA,
    input  logic [1:0]       RRESP
);

    master_state_t    state, state_nxt;
    logic             aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic             awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic [WIDTH-1:0] awaddr_nxt, wdata_nxt, araddr_nxt, rsp_rdata_nxt;
    logic [STRB-1:0]  wstrb_nxt;
    logic [2:0]       awprot_nxt, arprot_nxt;
    logic             rsp_valid_nxt, rsp_write_nxt;
    logic [1:0]       rsp_resp_nxt;

    // Gated with the reset so cmd_ready is low while the block is held in reset.
    assign cmd_ready = ARESETn && (state == S_IDLE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= S_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            AWVALID   <= 1'b0;
            AWADDR    <= '0;
            AWPROT    <= '0;
            WVALID    <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            ARPROT    <= '0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            state     <= state_nxt;
            aw_done   <= aw_done_nxt;
            w_done    <= w_done_nxt;
            AWVALID   <= awvalid_nxt;
            AWADDR    <= awaddr_nxt;
            AWPROT    <= awprot_nxt;
            WVALID    <= wvalid_nxt;
            WDATA     <= wdata_nxt;
            WSTRB     <= wstrb_nxt;
            BREADY    <= bready_nxt;
            ARVALID   <= arvalid_nxt;
            ARADDR    <= araddr_nxt;
            ARPROT    <= arprot_nxt;
            RREADY    <= rready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_write <= rsp_write_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_resp  <= rsp_resp_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        awvalid_nxt   = AWVALID;
        awaddr_nxt    = AWADDR;
        awprot_nxt    = AWPROT;
        wvalid_nxt    = WVALID;
        wdata_nxt     = WDATA;
        wstrb_nxt     = WSTRB;
        bready_nxt    = BREADY;
        arvalid_nxt   = ARVALID;
        araddr_nxt    = ARADDR;
        arprot_nxt    = ARPROT;
        rready_nxt    = RREADY;
        rsp_valid_nxt = rsp_valid;
        rsp_write_nxt = rsp_write;
        rsp_rdata_nxt = rsp_rdata;
        rsp_resp_nxt  = rsp_resp;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_nxt  = cmd_addr;
                        awprot_nxt  = cmd_prot;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                        state_nxt   = S_WR;
                    end else begin
                        araddr_nxt  = cmd_addr;
                        arprot_nxt  = cmd_prot;
                        arvalid_nxt = 1'b1;
                        state_nxt   = S_RADDR;
                    end
                end
            end
            // AW and W complete independently; the sticky flags let either order work.
            S_WR: begin
                if (AWVALID && AWREADY) begin
                    awvalid_nxt = 1'b0;
                    aw_done_nxt = 1'b1;
                end
                if (WVALID && WREADY) begin
                    wvalid_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
                if (aw_done_nxt && w_done_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (BVALID && BREADY) begin
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = BRESP;
                    state_nxt     = S_RSP;
                end
            end
            S_RADDR: begin
                if (ARVALID && ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (RVALID && RREADY) begin
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b0;
                    rsp_rdata_nxt = RDATA;
                    rsp_resp_nxt  = RRESP;
                    state_nxt     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4lite_master.sv
// Self-checking bench for axi4lite_master: a scripted slave serves each channel
// with programmable wait states while a scoreboard checks the responses.
module tb_axi4lite_master;
    import axi4lite_pkg::*;

    localparam int WIDTH = 32;
    localparam int STRB  = WIDTH / 8;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [WIDTH-1:0] cmd_addr, cmd_wdata;
    logic [STRB-1:0]  cmd_wstrb;
    logic [2:0]       cmd_prot;
    logic             rsp_valid, rsp_ready, rsp_write;
    logic [WIDTH-1:0] rsp_rdata;
    logic [1:0]       rsp_resp;
    logic             AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic             ARVALID, ARREADY, RVALID, RREADY;
    logic [WIDTH-1:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]       AWPROT, ARPROT;
    logic [STRB-1:0]  WSTRB;
    logic [1:0]       BRESP, RRESP;

    typedef struct {
        logic             write;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
        logic [STRB-1:0]  wstrb;
        logic [2:0]       prot;
        int               aw_d, w_d, b_d, ar_d, r_d, hold;
        logic [WIDTH-1:0] sdata;
        logic [1:0]       sresp;
        logic             exp_write;
        logic [WIDTH-1:0] exp_rdata;
        logic [1:0]       exp_resp;
    } vec_t;

    typedef struct {
        logic             write;
        logic [WIDTH-1:0] rdata;
        logic [1:0]       resp;
        int               accept_cyc;
        int               latency;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   tests = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rsp_cyc = 0;
    int   last_accept_cyc = 0;

    axi4lite_master #(.WIDTH(WIDTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic anyOutput();
        return |{cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, AWVALID, AWADDR, AWPROT,
                 WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, ARPROT, RREADY};
    endfunction

    task automatic driveCommand(input vec_t v);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.wstrb;
        cmd_prot  = v.prot;
    endtask

    // Holds the command until accepted and records what the response must be.
    task automatic issueCommand(input vec_t v);
        int   n = 0;
        exp_t e;
        driveCommand(v);
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        checkValue("cmd_ready_seen", cmd_ready, 1);
        e.write      = v.exp_write;
        e.rdata      = v.exp_rdata;
        e.resp       = v.exp_resp;
        e.accept_cyc = cyc;
        e.latency    = v.write ? 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d
                               : 3 + v.ar_d + v.r_d;
        last_accept_cyc = cyc;
        tick();
        cmd_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic serveAw(input int d, input logic [WIDTH-1:0] addr, input logic [2:0] prot);
        int n = 0;
        while (!AWVALID && n < 50) begin
            tick();
            n++;
        end
        checkValue("awvalid_seen", AWVALID, 1);
        for (int i = 0; i < d; i++) begin
            checkValue("awvalid_hold", AWVALID, 1);
            checkValue("bready_early", BREADY, 0);
            tick();
        end
        checkValue("awaddr", AWADDR, addr);
        checkValue("awprot", AWPROT, prot);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        checkValue("awvalid_drop", AWVALID, 0);
    endtask

    task automatic serveW(input int d, input logic [WIDTH-1:0] data, input logic [STRB-1:0] strb);
        int n = 0;
        while (!WVALID && n < 50) begin
            tick();
            n++;
        end
        checkValue("wvalid_seen", WVALID, 1);
        for (int i = 0; i < d; i++) begin
            checkValue("wvalid_hold", WVALID, 1);
            tick();
        end
        checkValue("wdata", WDATA, data);
        checkValue("wstrb", WSTRB, strb);
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        checkValue("wvalid_drop", WVALID, 0);
    endtask

    task automatic serveRespB(input int d, input logic [1:0] resp);
        checkValue("bready_up", BREADY, 1);
        for (int i = 0; i < d; i++) begin
            checkValue("rsp_early_b", rsp_valid, 0);
            tick();
        end
        BVALID = 1'b1;
        BRESP  = resp;
        tick();
        BVALID = 1'b0;
        BRESP  = 2'b00;
        checkValue("bready_drop", BREADY, 0);
    endtask

    task automatic serveAr(input int d, input logic [WIDTH-1:0] addr, input logic [2:0] prot);
        int n = 0;
        while (!ARVALID && n < 50) begin
            tick();
            n++;
        end
        checkValue("arvalid_seen", ARVALID, 1);
        for (int i = 0; i < d; i++) begin
            checkValue("arvalid_hold", ARVALID, 1);
            checkValue("rready_early", RREADY, 0);
            tick();
        end
        checkValue("araddr", ARADDR, addr);
        checkValue("arprot", ARPROT, prot);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        checkValue("arvalid_drop", ARVALID, 0);
    endtask

    task automatic serveRespR(input int d, input logic [WIDTH-1:0] data, input logic [1:0] resp);
        checkValue("rready_up", RREADY, 1);
        for (int i = 0; i < d; i++) begin
            checkValue("rsp_early_r", rsp_valid, 0);
            tick();
        end
        RVALID = 1'b1;
        RDATA  = data;
        RRESP  = resp;
        tick();
        RVALID = 1'b0;
        RDATA  = '0;
        RRESP  = 2'b00;
        checkValue("rready_drop", RREADY, 0);
    endtask

    task automatic serveSlave(input vec_t v);
        if (v.write) begin
            fork
                serveAw(v.aw_d, v.addr, v.prot);
                serveW(v.w_d, v.wdata, v.wstrb);
            join
            serveRespB(v.b_d, v.sresp);
        end else begin
            serveAr(v.ar_d, v.addr, v.prot);
            serveRespR(v.r_d, v.sdata, v.sresp);
        end
    endtask

    // Waits for the response, applies backpressure and compares against the scoreboard.
    task automatic checkOutput(input int hold);
        int               n = 0;
        exp_t             e;
        logic             s_write;
        logic [WIDTH-1:0] s_rdata;
        logic [1:0]       s_resp;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        checkValue("rsp_valid_seen", rsp_valid, 1);
        if (sb.size() == 0) begin
            checkValue("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        checkValue("rsp_latency", cyc - e.accept_cyc, e.latency);
        s_write = rsp_write;
        s_rdata = rsp_rdata;
        s_resp  = rsp_resp;
        for (int i = 0; i < hold; i++) begin
            tick();
            checkValue("rsp_hold_valid", rsp_valid, 1);
            checkValue("rsp_hold_stable", {rsp_write, rsp_rdata, rsp_resp}, {s_write, s_rdata, s_resp});
            checkValue("hold_cmd_ready", cmd_ready, 0);
            checkValue("hold_axi_valid", {AWVALID, WVALID, ARVALID}, 0);
        end
        checkValue("rsp_write", rsp_write, e.write);
        checkValue("rsp_rdata", rsp_rdata, e.rdata);
        checkValue("rsp_resp", rsp_resp, e.resp);
        rsp_ready    = 1'b1;
        last_rsp_cyc = cyc;
        tick();
        rsp_ready = 1'b0;
        checkValue("rsp_valid_drop", rsp_valid, 0);
        checkValue("cmd_ready_after_rsp", cmd_ready, 1);
        checkValue("axi_idle_after_rsp", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        issueCommand(v);
        serveSlave(v);
        checkOutput(v.hold);
    endtask

    initial begin
        vec_t wr, rd;

        vecs[0] = '{write:1'b1, addr:32'h10, wdata:32'hDEADBEEF, wstrb:4'hF, prot:3'b000,
                    aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0, hold:0, sdata:32'h0, sresp:OKAY,
                    exp_write:1'b1, exp_rdata:32'h0, exp_resp:OKAY};
        vecs[1] = '{write:1'b1, addr:32'h24, wdata:32'hCAFEF00D, wstrb:4'h3, prot:3'b010,
                    aw_d:3, w_d:0, b_d:5, ar_d:0, r_d:0, hold:0, sdata:32'h0, sresp:OKAY,
                    exp_write:1'b1, exp_rdata:32'h0, exp_resp:OKAY};
        vecs[2] = '{write:1'b0, addr:32'h30, wdata:32'h0, wstrb:4'h0, prot:3'b001,
                    aw_d:0, w_d:0, b_d:0, ar_d:2, r_d:4, hold:0, sdata:32'h12345678, sresp:SLVERR,
                    exp_write:1'b0, exp_rdata:32'h12345678, exp_resp:SLVERR};
        vecs[3] = '{write:1'b0, addr:32'h44, wdata:32'h0, wstrb:4'h0, prot:3'b100,
                    aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0, hold:6, sdata:32'hA5A5_0F0F, sresp:OKAY,
                    exp_write:1'b0, exp_rdata:32'hA5A5_0F0F, exp_resp:OKAY};
        vecs[4] = '{write:1'b1, addr:32'h58, wdata:32'h0BAD_F00D, wstrb:4'h5, prot:3'b101,
                    aw_d:0, w_d:2, b_d:1, ar_d:0, r_d:0, hold:2, sdata:32'h0, sresp:DECERR,
                    exp_write:1'b1, exp_rdata:32'h0, exp_resp:DECERR};
        vecs[5] = '{write:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, wstrb:4'h0, prot:3'b111,
                    aw_d:0, w_d:0, b_d:0, ar_d:1, r_d:0, hold:1, sdata:32'h8000_0001, sresp:EXOKAY,
                    exp_write:1'b0, exp_rdata:32'h8000_0001, exp_resp:EXOKAY};

        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;

        repeat (2) tick();
        checkValue("reset_outputs_zero", anyOutput(), 0);
        checkValue("reset_cmd_ready", cmd_ready, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checkValue("post_reset_cmd_ready", cmd_ready, 1);
        tick();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Back-to-back: the read is presented while the write response is still pending.
        wr = vecs[0];
        wr.addr = 32'h100;
        wr.wdata = 32'h1111_2222;
        wr.exp_rdata = 32'h0;
        rd = vecs[2];
        rd.addr = 32'h104;
        rd.ar_d = 0;
        rd.r_d = 0;
        rd.sdata = 32'h3333_4444;
        rd.sresp = OKAY;
        rd.exp_rdata = 32'h3333_4444;
        rd.exp_resp = OKAY;
        issueCommand(wr);
        serveSlave(wr);
        driveCommand(rd);
        checkOutput(0);
        issueCommand(rd);
        checkValue("b2b_accept_gap", last_accept_cyc - last_rsp_cyc, 1);
        serveSlave(rd);
        checkOutput(0);

        // Reset in the middle of a write whose AW/W are never accepted.
        wr.addr = 32'h40;
        issueCommand(wr);
        tick();
        checkValue("midwr_awvalid", AWVALID, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        checkValue("midwr_async_zero", anyOutput(), 0);
        sb.delete();
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checkValue("midwr_cmd_ready", cmd_ready, 1);
        tick();
        checkValue("midwr_no_valid", {AWVALID, WVALID, ARVALID, rsp_valid}, 0);
        rd.addr = 32'h200;
        rd.sdata = 32'h5555_AAAA;
        rd.exp_rdata = 32'h5555_AAAA;
        applyStimulus(rd);

        checkValue("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi4lite_master.md
Name: axi4lite_master

Overview:
- Single-outstanding AXI4-Lite master. Converts a simple command/response request port into AXI4-Lite write (AW/W/B) and read (AR/R) channel traffic.
- Sits directly upstream of the team's AXI4-Lite slave block and drives its five channels.
- Used by test/control logic and simple CPUs that need register access without handling AXI handshakes themselves.

Parameters:
- WIDTH, 32, address and data width in bits; must be a multiple of 8.
- STRB, WIDTH/8, write-strobe width, derived; do not override.

Ports:
- ACLK  in  1  clock; everything is sampled on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  WIDTH  byte address.
- cmd_wdata  in  WIDTH  write data; ignored for reads.
- cmd_wstrb  in  STRB  byte enables; ignored for reads.
- cmd_prot  in  3  protection bits {instruction, non-secure, privileged}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP passed through unchanged.
- AWVALID out 1, AWREADY in 1, AWADDR out WIDTH, AWPROT out 3.
- WVALID out 1, WREADY in 1, WDATA out WIDTH, WSTRB out STRB.
- BVALID in 1, BREADY out 1, BRESP in 2.
- ARVALID out 1, ARREADY in 1, ARADDR out WIDTH, ARPROT out 3.
- RVALID in 1, RREADY out 1, RDATA in WIDTH, RRESP in 2.

Behaviour:
- Clocking and reset: one clock, ACLK. ARESETn is asynchronous active-low.
- While ARESETn is low, every output is 0, including cmd_ready, all xVALID, BREADY, RREADY, rsp_*, and the address/data/strobe/prot outputs.
- Reset asserted mid-transaction aborts immediately. No response is delivered, and the FSM restarts in IDLE.
- All AXI outputs and rsp_* are registered. cmd_ready = (state == IDLE) and is decoded from the state register.
- FSM states: IDLE, WR, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr/wdata/wstrb/prot/write into the output registers.
  - Write: go to WR, with AWVALID = WVALID = 1 from the next cycle.
  - Read: go to RADDR, with ARVALID = 1 from the next cycle.
- WR:
  - AW and W are independent. Each VALID drops the cycle after its own handshake (xVALID & xREADY); sticky flags aw_done/w_done record completion.
  - The slave may accept them in either order or in the same cycle.
  - When both are complete (including same-cycle), go to WRESP with BREADY = 1.
  - A VALID is never withdrawn before its handshake. Address, data, strobe and prot stay stable while VALID is high.
- WRESP:
  - On BVALID & BREADY, capture BRESP, set rsp_write = 1 and rsp_rdata = 0, drop BREADY, go to RSP.
- RADDR:
  - On ARVALID & ARREADY, drop ARVALID, raise RREADY, go to RDATA.
- RDATA:
  - On RVALID & RREADY, capture RDATA/RRESP, set rsp_write = 0, drop RREADY, go to RSP.
- RSP:
  - rsp_valid = 1, with rsp_* held stable until rsp_ready.
  - On the handshake, go to IDLE; cmd_ready rises the following cycle.
- Latency with zero-wait slave and consumer: command accepted at cycle 0, xVALID at 1, BREADY/RREADY at 2, rsp_valid at 3.
  - Throughput is one transaction per 4 cycles minimum.
- BVALID/RVALID arriving while BREADY/RREADY is low are ignored; the slave must hold them.
- Error responses (SLVERR/DECERR) are reported, never retried. The FSM returns to IDLE normally.
- Only one transaction is outstanding at a time; no reordering is possible.

Decomposition:
- Shared package axi4lite_pkg holds:
  - response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - AxPROT bit indices (PRIV=0, NONSEC=1, INSTR=2);
  - the master FSM state enum.
- No sub-module. The design is one FSM plus channel registers.

Test Plan:
- Zero-wait write: cmd write addr 0x10, data 0xDEADBEEF, wstrb 0xF, slave ready/BVALID immediately, BRESP OKAY → AWADDR 0x10 and WDATA 0xDEADBEEF at cycle 1; rsp_valid at cycle 3 with rsp_write = 1 and rsp_resp = 00.
- Skewed write: WREADY 3 cycles before AWREADY, then BVALID delayed 5 cycles → WVALID drops after its handshake while AWVALID holds; BREADY asserts only after both complete; one response.
- Read with wait states: ARREADY after 2 cycles, RVALID after 4 more with RDATA 0x12345678 and RRESP 10 → rsp_rdata 0x12345678, rsp_resp = SLVERR, rsp_write = 0.
- Response backpressure: rsp_ready low for 6 cycles → rsp_* stable; cmd_ready stays 0 and no AXI VALID is asserted until the cycle after rsp_ready.
- Reset mid-write: deassert ARESETn while AWVALID = 1 → all outputs 0 asynchronously; after release, cmd_ready = 1 and a fresh read completes correctly.
- Back-to-back: write then read, cmd_valid held high → second command accepted exactly one cycle after the first response handshake; no overlap on AXI channels.
